// File: rtl/mm_ctrl_pkg.sv
// Shared definitions for the matmul tile job sequencer: state codes and default sizing.
package mm_ctrl_pkg;

    localparam int DWIDTH_DEF     = 16;
    localparam int BB_SIZE_DEF    = 16;
    localparam int AWIDTH_DEF     = 7;
    localparam int LOAD_WORDS_DEF = 16;
    localparam int RD_WORDS_DEF   = 16;
    localparam int ADDR_LAT_DEF   = 2;
    localparam int RD_LAT_DEF     = 6;
    localparam int WB_LAT_DEF     = 2;
    localparam int FIFO_DEPTH_DEF = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE       = 3'd0;
    localparam state_t ST_LOAD_A     = 3'd1;
    localparam state_t ST_LOAD_B     = 3'd2;
    localparam state_t ST_LOAD_FLUSH = 3'd3;
    localparam state_t ST_COMPUTE    = 3'd4;
    localparam state_t ST_WB         = 3'd5;
    localparam state_t ST_READ       = 3'd6;
    localparam state_t ST_DONE       = 3'd7;

    function automatic int word_width(input int dwidth, input int bb_size);
        return dwidth * bb_size;
    endfunction

endpackage

// File: rtl/mm_rd_fifo.sv
// Show-ahead synchronous FIFO holding C words read back from the result BRAM.
module mm_rd_fifo
    import mm_ctrl_pkg::*;
#(
    parameter int W     = 256,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  pop_data,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A push into a full FIFO is accepted when the same cycle pops a word.
    assign do_pop  = pop && (count_reg != '0);
    assign do_push = push && ((count_reg != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= bump(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= bump(rd_ptr_reg);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign pop_data = (count_reg != '0) ? mem[rd_ptr_reg] : '0;
    assign count    = count_reg;

endmodule

// File: rtl/matmul_tile_ctrl.sv
// Job sequencer for the 32x32 systolic matmul: loads A/B, runs compute, streams C back.
// Optional compute-cycle counter enabled by defining MM_CTRL_PERF_CNT_EN.
module matmul_tile_ctrl
    import mm_ctrl_pkg::*;
#(
    parameter int DWIDTH     = DWIDTH_DEF,
    parameter int BB_SIZE    = BB_SIZE_DEF,
    parameter int AWIDTH     = AWIDTH_DEF,
    parameter int LOAD_WORDS = LOAD_WORDS_DEF,
    parameter int RD_WORDS   = RD_WORDS_DEF,
    parameter int ADDR_LAT   = ADDR_LAT_DEF,
    parameter int RD_LAT     = RD_LAT_DEF,
    parameter int WB_LAT     = WB_LAT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int W          = word_width(DWIDTH, BB_SIZE)
) (
    input  logic              clk,
    input  logic              reset_0,
    input  logic              job_start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_data,
    output logic              busy,
    output logic              job_done,
    output logic              enable_writing_to_mem,
    output logic              enable_reading_from_mem,
    output logic [AWIDTH-1:0] addr_pi,
    output logic [W-1:0]      data_pi,
    output logic              we_a,
    output logic              we_b,
    output logic              we_c,
    output logic              start_mat_mul_0,
    input  logic              done_mat_mul,
    input  logic [W-1:0]      data_from_out_mat,
    output logic [31:0]       perf_cycles
);

    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int FW  = $clog2(ADDR_LAT + 1) + 1;
    localparam int WBW = $clog2(WB_LAT + 1) + 1;

    state_t            state_reg;
    logic [AWIDTH-1:0] wc_reg;
    logic [AWIDTH-1:0] rc_reg;
    logic [AWIDTH-1:0] pc_reg;
    logic [AWIDTH-1:0] addr_reg;
    logic [FW-1:0]     flush_cnt_reg;
    logic [WBW-1:0]    wb_cnt_reg;
    logic              first_reg;
    logic [CW-1:0]     outstanding_reg;
    logic [CW-1:0]     fifo_count;
    logic [W-1:0]      wp_data_reg [ADDR_LAT+1];
    logic [ADDR_LAT:0] wp_a_reg;
    logic [ADDR_LAT:0] wp_b_reg;
    logic [RD_LAT:0]   rd_vld_reg;
    logic              loading;
    logic              hs;
    logic              wc_last;
    logic              issue;
    logic              push;
    logic              pop;

    assign loading = (state_reg == ST_LOAD_A) || (state_reg == ST_LOAD_B);
    assign hs      = in_valid && loading;
    assign wc_last = (wc_reg == AWIDTH'(LOAD_WORDS - 1));

    // Reads in flight plus words already queued may never exceed the FIFO, so no push is dropped.
    assign issue = (state_reg == ST_READ) && (rc_reg != AWIDTH'(RD_WORDS)) &&
                   (({1'b0, outstanding_reg} + {1'b0, fifo_count}) < (CW + 1)'(FIFO_DEPTH));
    assign push  = rd_vld_reg[RD_LAT];
    assign pop   = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset_0) begin
        if (reset_0) begin
            state_reg     <= ST_IDLE;
            wc_reg        <= '0;
            rc_reg        <= '0;
            pc_reg        <= '0;
            addr_reg      <= '0;
            flush_cnt_reg <= '0;
            wb_cnt_reg    <= '0;
            first_reg     <= 1'b0;
        end else begin
            if (hs) begin
                addr_reg <= wc_reg;
            end else if (issue) begin
                addr_reg <= rc_reg;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (job_start) begin
                        state_reg <= ST_LOAD_A;
                        wc_reg    <= '0;
                    end
                end
                ST_LOAD_A, ST_LOAD_B: begin
                    if (hs) begin
                        if (wc_last) begin
                            wc_reg <= '0;
                            if (state_reg == ST_LOAD_A) begin
                                state_reg <= ST_LOAD_B;
                            end else begin
                                state_reg     <= ST_LOAD_FLUSH;
                                flush_cnt_reg <= '0;
                            end
                        end else begin
                            wc_reg <= wc_reg + 1'b1;
                        end
                    end
                end
                ST_LOAD_FLUSH: begin
                    if (flush_cnt_reg == FW'(ADDR_LAT)) begin
                        state_reg <= ST_COMPUTE;
                        first_reg <= 1'b1;
                    end else begin
                        flush_cnt_reg <= flush_cnt_reg + 1'b1;
                    end
                end
                ST_COMPUTE: begin
                    // A done seen on the first cycle is stale from the previous run.
                    first_reg <= 1'b0;
                    if (done_mat_mul && !first_reg) begin
                        state_reg  <= ST_WB;
                        wb_cnt_reg <= '0;
                    end
                end
                ST_WB: begin
                    if (wb_cnt_reg == WBW'(WB_LAT - 1)) begin
                        state_reg <= ST_READ;
                        rc_reg    <= '0;
                        pc_reg    <= '0;
                    end else begin
                        wb_cnt_reg <= wb_cnt_reg + 1'b1;
                    end
                end
                ST_READ: begin
                    if (issue) rc_reg <= rc_reg + 1'b1;
                    if (pop)   pc_reg <= pc_reg + 1'b1;
                    if (pop && (pc_reg == AWIDTH'(RD_WORDS - 1))) begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Write data and enables trail the address by ADDR_LAT so they meet it at the BRAM.
    always_ff @(posedge clk or posedge reset_0) begin
        if (reset_0) begin
            for (int i = 0; i <= ADDR_LAT; i++) begin
                wp_data_reg[i] <= '0;
            end
            wp_a_reg   <= '0;
            wp_b_reg   <= '0;
            rd_vld_reg <= '0;
        end else begin
            if (hs) wp_data_reg[0] <= in_data;
            wp_a_reg[0] <= hs && (state_reg == ST_LOAD_A);
            wp_b_reg[0] <= hs && (state_reg == ST_LOAD_B);
            for (int i = 1; i <= ADDR_LAT; i++) begin
                wp_data_reg[i] <= wp_data_reg[i-1];
                wp_a_reg[i]    <= wp_a_reg[i-1];
                wp_b_reg[i]    <= wp_b_reg[i-1];
            end
            rd_vld_reg[0] <= issue;
            for (int i = 1; i <= RD_LAT; i++) begin
                rd_vld_reg[i] <= rd_vld_reg[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset_0) begin
        if (reset_0) begin
            outstanding_reg <= '0;
        end else begin
            outstanding_reg <= outstanding_reg + CW'(issue) - CW'(push);
        end
    end

    mm_rd_fifo #(
        .W     (W),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_rd_fifo (
        .clk       (clk),
        .rst       (reset_0),
        .push      (push),
        .push_data (data_from_out_mat),
        .pop       (pop),
        .pop_data  (out_data),
        .count     (fifo_count)
    );

    assign out_valid               = (fifo_count != '0);
    assign in_ready                = loading;
    assign busy                    = (state_reg != ST_IDLE);
    assign job_done                = (state_reg == ST_DONE);
    assign enable_writing_to_mem   = loading || (state_reg == ST_LOAD_FLUSH);
    assign enable_reading_from_mem = (state_reg == ST_READ);
    assign start_mat_mul_0         = (state_reg == ST_COMPUTE);
    assign we_c                    = (state_reg == ST_COMPUTE) || (state_reg == ST_WB);
    assign addr_pi                 = addr_reg;
    assign data_pi                 = wp_data_reg[ADDR_LAT];
    assign we_a                    = wp_a_reg[ADDR_LAT];
    assign we_b                    = wp_b_reg[ADDR_LAT];

`ifdef MM_CTRL_PERF_CNT_EN
    logic [31:0] perf_reg;

    always_ff @(posedge clk or posedge reset_0) begin
        if (reset_0) begin
            perf_reg <= '0;
        end else if ((state_reg == ST_IDLE) && job_start) begin
            perf_reg <= '0;
        end else if (((state_reg == ST_COMPUTE) || (state_reg == ST_WB)) && (perf_reg != '1)) begin
            perf_reg <= perf_reg + 1'b1;
        end
    end

    assign perf_cycles = perf_reg;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_matmul_tile_ctrl.sv
// Self-checking bench for matmul_tile_ctrl: job table, BRAM/host models, reset-abort sequence.
module tb_matmul_tile_ctrl;

    localparam int W        = 256;
    localparam int AW       = 7;
    localparam int NW       = 16;
    localparam int ADDR_LAT = 2;
    localparam int RD_LAT   = 6;
    localparam int WB_LAT   = 2;
    localparam int DEPTH    = 8;
`ifdef MM_CTRL_PERF_CNT_EN
    localparam int PERF_ON  = 1;
`else
    localparam int PERF_ON  = 0;
`endif

    logic          clk;
    logic          reset_0;
    logic          job_start;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          busy;
    logic          job_done;
    logic          enable_writing_to_mem;
    logic          enable_reading_from_mem;
    logic [AW-1:0] addr_pi;
    logic [W-1:0]  data_pi;
    logic          we_a;
    logic          we_b;
    logic          we_c;
    logic          start_mat_mul_0;
    logic          done_mat_mul;
    logic [W-1:0]  data_from_out_mat;
    logic [31:0]   perf_cycles;

    matmul_tile_ctrl #(
        .DWIDTH(16), .BB_SIZE(16), .AWIDTH(AW), .LOAD_WORDS(NW), .RD_WORDS(NW),
        .ADDR_LAT(ADDR_LAT), .RD_LAT(RD_LAT), .WB_LAT(WB_LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk                     (clk),
        .reset_0                 (reset_0),
        .job_start               (job_start),
        .in_valid                (in_valid),
        .in_ready                (in_ready),
        .in_data                 (in_data),
        .out_valid               (out_valid),
        .out_ready               (out_ready),
        .out_data                (out_data),
        .busy                    (busy),
        .job_done                (job_done),
        .enable_writing_to_mem   (enable_writing_to_mem),
        .enable_reading_from_mem (enable_reading_from_mem),
        .addr_pi                 (addr_pi),
        .data_pi                 (data_pi),
        .we_a                    (we_a),
        .we_b                    (we_b),
        .we_c                    (we_c),
        .start_mat_mul_0         (start_mat_mul_0),
        .done_mat_mul            (done_mat_mul),
        .data_from_out_mat       (data_from_out_mat),
        .perf_cycles             (perf_cycles)
    );

    typedef struct {
        bit seq_data;
        int gap;
        bit stale;
        int done_after;
        int stall;
        bit rand_ready;
        bit pulse;
        int abort_at;
        int exp_perf;
    } job_t;

    int            n_pass;
    int            n_total;
    int            cyc;
    logic [AW-1:0] hist [0:RD_LAT];
    logic [W-1:0]  exp_a [NW];
    logic [W-1:0]  exp_b [NW];
    logic [W-1:0]  cmem [128];
    int            wtime_q [$];
    int            wr_idx_a;
    int            wr_idx_b;
    int            last_we_cyc;
    int            done_pulses;
    int            issued;
    bit            rd_seen;
    logic [AW-1:0] rd_prev;
    bit            mon_on;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        for (int k = 0; k < W / 32; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    // BRAM-side model: address history, C read data RD_LAT cycles after addr_pi, write observer.
    always @(negedge clk) begin
        int exp_t;
        for (int k = RD_LAT; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = addr_pi;
        data_from_out_mat = cmem[hist[RD_LAT]];
        if (mon_on) begin
            if (we_a || we_b) begin
                exp_t = (wtime_q.size() > 0) ? wtime_q.pop_front() : -1;
                check("write_cycle", cyc, exp_t);
                check("write_addr", hist[ADDR_LAT], we_a ? wr_idx_a : wr_idx_b);
                check("write_data", data_pi, we_a ? exp_a[wr_idx_a % NW] : exp_b[wr_idx_b % NW]);
                check("write_en_mem", enable_writing_to_mem, 1'b1);
                if (we_a) wr_idx_a++;
                else wr_idx_b++;
                last_we_cyc = cyc;
            end
            if (job_done) done_pulses++;
            if (enable_reading_from_mem) begin
                if (!rd_seen) begin
                    rd_seen = 1'b1;
                    rd_prev = addr_pi;
                end else if (addr_pi != rd_prev) begin
                    check("read_addr_order", addr_pi, issued);
                    issued++;
                    rd_prev = addr_pi;
                end
            end
        end
    end

    task automatic abort_with_reset();
        #2;
        reset_0 = 1'b1;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_out_data", out_data, '0);
        check("abort_we", {we_a, we_b, we_c}, 3'b000);
        check("abort_addr", addr_pi, '0);
        check("abort_data_pi", data_pi, '0);
        check("abort_ctrl", {start_mat_mul_0, enable_writing_to_mem, enable_reading_from_mem, job_done, in_ready}, 5'b0);
        check("abort_perf", perf_cycles, '0);
        tick();
        reset_0 = 1'b0;
        out_ready = 1'b0;
        tick();
        check("abort_no_done", done_pulses, 0);
        check("abort_idle", busy, 1'b0);
        mon_on = 1'b0;
    endtask

    task automatic run_job(input int id, input job_t j);
        int k;
        int g;
        int popped;
        int occ;
        int max_occ;
        bit want;
        bit rdy;
        bit start_ok;
        for (int i = 0; i < NW; i++) begin
            exp_a[i] = j.seq_data ? W'(i + 1) : rand_word();
            exp_b[i] = j.seq_data ? W'(i + 'h101) : rand_word();
            cmem[i]  = rand_word();
        end
        wtime_q.delete();
        wr_idx_a = 0; wr_idx_b = 0; done_pulses = 0; issued = 0; rd_seen = 1'b0;
        last_we_cyc = -10;
        mon_on = 1'b1;
        done_mat_mul = j.stale;
        job_start = 1'b1;
        tick();
        job_start = 1'b0;
        check("job_busy", busy, 1'b1);

        // Operand stream: A words then B words, with the table's valid pattern.
        k = 0;
        g = 0;
        while (k < 2 * NW && g < 400) begin
            want = (j.gap == 0) ? 1'b1 : (j.gap == 1) ? (g % 2 == 0) : 1'($urandom_range(0, 1));
            if (want && in_ready) begin
                in_valid = 1'b1;
                in_data  = (k < NW) ? exp_a[k] : exp_b[k - NW];
                wtime_q.push_back(cyc + 1 + ADDR_LAT);
                k++;
            end else begin
                in_valid = 1'b0;
                in_data  = rand_word();
            end
            tick();
            g++;
        end
        in_valid = 1'b0;
        check("load_accepted", k, 2 * NW);

        g = 0;
        while (!start_mat_mul_0 && g < 50) begin
            tick();
            g++;
        end
        check("start_seen", start_mat_mul_0, 1'b1);
        check("start_after_flush", cyc, last_we_cyc + 1);
        check("we_a_count", wr_idx_a, NW);
        check("we_b_count", wr_idx_b, NW);
        check("write_pending", wtime_q.size(), 0);

        // Compute: done lands in COMPUTE cycle done_after (cycle 1 is the current one).
        start_ok = 1'b1;
        done_mat_mul = (j.done_after == 1) || j.stale;
        for (int c = 2; c <= j.done_after; c++) begin
            tick();
            if (!start_mat_mul_0) start_ok = 1'b0;
            job_start    = j.pulse && (c == 3);
            done_mat_mul = (c == j.done_after);
        end
        tick();
        job_start    = 1'b0;
        done_mat_mul = 1'b0;
        check("start_held", start_ok, 1'b1);
        check("start_fall", start_mat_mul_0, 1'b0);
        check("we_c_wb1", we_c, 1'b1);
        tick();
        check("we_c_wb2", we_c, 1'b1);
        tick();
        check("we_c_read", we_c, 1'b0);
        check("read_enable", enable_reading_from_mem, 1'b1);
        check("perf_cycles", perf_cycles, j.exp_perf);

        // Readback with host backpressure; C must arrive in address order.
        popped  = 0;
        max_occ = 0;
        g = 0;
        while (popped < NW && g < 600) begin
            if (j.abort_at > 0 && g == j.abort_at) begin
                abort_with_reset();
                $display("job %0d: aborted by reset after %0d read cycles, %0d words popped", id, g, popped);
                return;
            end
            rdy = (g < j.stall) ? 1'b0 : (j.rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
            out_ready = rdy;
            occ = issued - popped;
            if (occ > max_occ) max_occ = occ;
            if (out_valid && rdy) begin
                check("out_data", out_data, cmem[popped]);
                popped++;
            end
            tick();
            g++;
        end
        out_ready = 1'b0;
        check("words_popped", popped, NW);
        check("inflight_le_depth", max_occ <= DEPTH, 1'b1);
        if (j.stall >= 2 * DEPTH) check("inflight_fills_fifo", max_occ, DEPTH);
        check("job_done_pulse", job_done, 1'b1);
        tick();
        check("idle_after_job", busy, 1'b0);
        check("job_done_count", done_pulses, 1);
        check("reads_issued", issued, NW);
        check("perf_hold", perf_cycles, j.exp_perf);
        mon_on = 1'b0;
        $display("job %0d: done_after=%0d stall=%0d max_inflight=%0d perf=%0d", id, j.done_after, j.stall, max_occ, perf_cycles);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        job_t tbl [5];
        int   da;
        n_pass = 0; n_total = 0; cyc = 0; mon_on = 1'b0;
        reset_0 = 1'b1; job_start = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; done_mat_mul = 1'b0; data_from_out_mat = '0;
        for (int i = 0; i <= RD_LAT; i++) hist[i] = '0;
        for (int i = 0; i < 128; i++) cmem[i] = '0;

        da = $urandom_range(3, 60);
        tbl[0] = '{1, 0, 0, 40, 20, 0, 0, 0,  PERF_ON * (40 + WB_LAT)};
        tbl[1] = '{0, 1, 1, 10, 0,  1, 1, 0,  PERF_ON * (10 + WB_LAT)};
        tbl[2] = '{0, 2, 0, 5,  20, 0, 0, 12, PERF_ON * (5 + WB_LAT)};
        tbl[3] = '{0, 2, 1, 2,  3,  1, 0, 0,  PERF_ON * (2 + WB_LAT)};
        tbl[4] = '{0, 2, 0, da, int'($urandom_range(0, 25)), 1, 0, 0, PERF_ON * (da + WB_LAT)};

        repeat (3) tick();
        check("reset_busy", busy, 1'b0);
        check("reset_in_ready", in_ready, 1'b0);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_we", {we_a, we_b, we_c}, 3'b000);
        check("reset_addr", addr_pi, '0);
        check("reset_perf", perf_cycles, '0);
        reset_0 = 1'b0;
        tick();

        for (int r = 0; r < 5; r++) begin
            run_job(r, tbl[r]);
            repeat (2) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/matmul_tile_ctrl.md
Name: matmul_tile_ctrl

Overview:
- Job sequencer for the 32x32 matmul built from 16x16 systolic tiles and its A/B/C BRAMs.
- Accepts operand words from a host stream and writes them into the A, then B, BRAMs through the shared addr_pi/data_pi port.
- Pulses the matmul start, waits for done, then reads matrix C back out to a host stream with backpressure.
- Sits between the host interface and the matrix_multiplication top-level pins.

Parameters:
- DWIDTH, 16, element width.
- BB_SIZE, 16, elements per BRAM word; word width W = BB_SIZE*DWIDTH = 256.
- AWIDTH, 7, BRAM address width.
- LOAD_WORDS, 16, words written per operand (addresses 0..LOAD_WORDS-1).
- RD_WORDS, 16, C words read back.
- ADDR_LAT, 2, register stages on the addr path ahead of the BRAM; data/we are delayed by this amount.
- RD_LAT, 6, cycles from addr_pi to valid data_from_out_mat.
- WB_LAT, 2, cycles we_c stays high after done_mat_mul.
- FIFO_DEPTH, 8, readback FIFO depth; must be at least RD_LAT+2.

Ports:
- clk  in  1  clock.
- reset_0  in  1  asynchronous, active-high reset.
- job_start  in  1  one-cycle pulse that starts a job; ignored unless idle.
- in_valid  in  1  operand word valid.
- in_ready  out  1  operand word accepted when in_valid&in_ready.
- in_data  in  W  operand word.
- out_valid  out  1  C word valid.
- out_ready  in  1  host ready for a C word.
- out_data  out  W  C word.
- busy  out  1  high in every state except IDLE.
- job_done  out  1  one-cycle pulse when the job completes.
- enable_writing_to_mem  out  1  selects addr_pi for A/B.
- enable_reading_from_mem  out  1  selects addr_pi for C.
- addr_pi  out  AWIDTH  BRAM address.
- data_pi  out  W  BRAM write data.
- we_a, we_b, we_c  out  1 each  BRAM write enables.
- start_mat_mul_0  out  1  matmul run (level).
- done_mat_mul  in  1  matmul done.
- data_from_out_mat  in  W  C readback data.
- perf_cycles  out  32  compute-cycle count (see Optional Feature).

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0, FIFO empty. Reset in any state aborts the job with no job_done pulse.
- FSM states: IDLE, LOAD_A, LOAD_B, LOAD_FLUSH, COMPUTE, WB, READ, DONE.
- IDLE:
  - job_start -> LOAD_A, word counter wc=0.
  - job_start while busy is ignored.
- LOAD_A / LOAD_B:
  - in_ready=1; enable_writing_to_mem=1.
  - On each handshake: addr_pi=wc, and data_pi/we_a (or we_b) are driven ADDR_LAT cycles later through a delay pipe, so data and enable meet the registered address at the BRAM.
  - Between handshakes: we=0, addr_pi holds its last value.
  - When wc reaches LOAD_WORDS-1 on a handshake: LOAD_A -> LOAD_B (wc=0); LOAD_B -> LOAD_FLUSH.
- LOAD_FLUSH:
  - Lasts ADDR_LAT+1 cycles; in_ready=0.
  - enable_writing_to_mem stays high until the delay pipe has drained, then drops -> COMPUTE.
- COMPUTE:
  - start_mat_mul_0=1, we_c=1.
  - done_mat_mul=1 -> drop start_mat_mul_0 the next cycle -> WB.
  - done_mat_mul sampled in the first COMPUTE cycle is ignored (left over from the previous job).
- WB: we_c held for WB_LAT cycles, then 0 -> READ.
- READ:
  - enable_reading_from_mem=1.
  - Issue read address rc only when outstanding + fifo_count < FIFO_DEPTH; the issued read's data is pushed into the FIFO RD_LAT cycles later (valid shift pipe).
  - out_valid = FIFO not empty; pop on out_valid&out_ready.
  - Simultaneous push and pop on a full FIFO is legal; the count is unchanged.
  - After RD_WORDS issued and RD_WORDS popped -> DONE.
- DONE: job_done=1 for one cycle, enable_reading_from_mem=0 -> IDLE.
- Address arithmetic: wc and rc are AWIDTH bits and never wrap within a job.

Optional Feature:
- Macro MM_CTRL_PERF_CNT_EN.
- Defined: perf_cycles clears on job_start, increments every cycle in COMPUTE and WB, saturates at 2^32-1, and holds after the job.
- Undefined: perf_cycles tied to 0 and no counter logic.

Decomposition:
- Shared package mm_ctrl_pkg: FSM state enum, W derivation, default latency constants.
- One sub-module: mm_rd_fifo, a synchronous FIFO of width W and depth FIFO_DEPTH with count output.

Test Plan:
- Load 16 A words 0x1..0x10 and 16 B words -> we_a high for exactly 16 cycles, each data_pi equal to the word written ADDR_LAT cycles after its addr_pi (0..15); then we_b likewise; start_mat_mul_0 rises after LOAD_FLUSH.
- in_valid toggled 1/0 during load -> no write on gap cycles; addresses stay contiguous 0..15.
- done_mat_mul asserted 40 cycles into COMPUTE -> start_mat_mul_0 falls next cycle, we_c falls after 2 more cycles; perf_cycles=42 with the macro, 0 without.
- Readback with out_ready held 0 for 20 cycles -> at most 8 reads outstanding/queued, no data loss; all 16 C words are delivered in address order once released.
- job_start pulsed during COMPUTE -> ignored, exactly one job_done.
- reset_0 asserted mid-READ -> all outputs 0 immediately (asynchronous); a subsequent job runs cleanly.
